// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch-to-decode instruction queue.
package fetch_pkg;

    localparam int INSTR_W          = 32;
    localparam int FQ_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } fq_occ_e;

endpackage

// File: rtl/fq_ptr.sv
// Wrap-bit pointer register: MSB is the lap bit, low bits index the storage array.
module fq_ptr #(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          clear_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Clear beats increment so a flush in the same cycle as a handshake wins.
    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Circular FIFO of {pc, instr} pairs between fetch and decode, flushed on a taken branch.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_F,
    input  logic                 enq_valid_F,
    output logic                 enq_ready_F,
    input  logic [N-1:0]         enq_pc_F,
    input  logic [INSTR_W-1:0]   enq_instr_F,
    output logic                 deq_valid_D,
    input  logic                 deq_ready_D,
    output logic [N-1:0]         deq_pc_D,
    output logic [INSTR_W-1:0]   deq_instr_D,
    output logic [$clog2(DEPTH):0] count_F
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [N-1:0]       pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    fq_entry_t     mem_q [DEPTH];
    fq_entry_t     head;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          ptr_clear;
    logic          empty;
    logic          full;
    logic          enq_fire;
    logic          deq_fire;

    // Handshake: a transfer happens on a rising edge where valid && ready; ready
    // and valid outputs come only from the pointer registers, so there is no
    // bypass when full or empty and no combinational path from any input.
    assign ptr_clear = reset || flush_F;
    assign empty     = (rd_ptr == wr_ptr);
    assign full      = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
    assign enq_fire  = enq_valid_F && !full && !ptr_clear;
    assign deq_fire  = deq_ready_D && !empty && !ptr_clear;

    fq_ptr #(.PW(PW)) u_wr_ptr (
        .clk     (clk),
        .clear_i (ptr_clear),
        .inc_i   (enq_fire),
        .ptr_o   (wr_ptr)
    );

    fq_ptr #(.PW(PW)) u_rd_ptr (
        .clk     (clk),
        .clear_i (ptr_clear),
        .inc_i   (deq_fire),
        .ptr_o   (rd_ptr)
    );

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_q[wr_ptr[AW-1:0]] <= '{pc: enq_pc_F, instr: enq_instr_F};
        end
    end

    assign head = mem_q[rd_ptr[AW-1:0]];

    // Zero the payload when empty so stale or reset-time storage never looks like an entry.
    assign enq_ready_F = !full;
    assign deq_valid_D = !empty;
    assign deq_pc_D    = empty ? '0 : head.pc;
    assign deq_instr_D = empty ? '0 : head.instr;
    assign count_F     = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue-based reference model plus literal spot checks.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int N     = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush_F;
    logic          enq_valid_F;
    logic          enq_ready_F;
    logic [N-1:0]  enq_pc_F;
    logic [31:0]   enq_instr_F;
    logic          deq_valid_D;
    logic          deq_ready_D;
    logic [N-1:0]  deq_pc_D;
    logic [31:0]   deq_instr_D;
    logic [2:0]    count_F;

    int checks = 0;
    int errors = 0;

    // Reference model: the queue contents as plain SV queues.
    logic [N-1:0] exp_q[$];
    logic [31:0]  exp_instr_q[$];
    bit           model_live = 1'b0;
    bit           do_enq;
    bit           do_deq;
    bit           seen_40 = 1'b0;
    bit           saw_empty = 1'b0;
    bit           saw_partial = 1'b0;
    bit           saw_full = 1'b0;

    fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush_F     (flush_F),
        .enq_valid_F (enq_valid_F),
        .enq_ready_F (enq_ready_F),
        .enq_pc_F    (enq_pc_F),
        .enq_instr_F (enq_instr_F),
        .deq_valid_D (deq_valid_D),
        .deq_ready_D (deq_ready_D),
        .deq_pc_D    (deq_pc_D),
        .deq_instr_D (deq_instr_D),
        .count_F     (count_F)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model update on each edge ----------------
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_instr_q.delete();
            model_live = 1'b1;
        end else if (model_live) begin
            if (flush_F) begin
                exp_q.delete();
                exp_instr_q.delete();
            end else begin
                do_deq = (exp_q.size() > 0) && deq_ready_D;
                do_enq = enq_valid_F && (exp_q.size() < DEPTH);
                if (do_deq && deq_pc_D == 64'h40) seen_40 = 1'b1;
                if (do_deq) begin
                    void'(exp_q.pop_front());
                    void'(exp_instr_q.pop_front());
                end
                if (do_enq) begin
                    exp_q.push_back(enq_pc_F);
                    exp_instr_q.push_back(enq_instr_F);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_live) begin
            check("count", 64'(count_F), 64'(exp_q.size()));
            check("enq_ready", 64'(enq_ready_F), 64'(exp_q.size() < DEPTH));
            check("deq_valid", 64'(deq_valid_D), 64'(exp_q.size() > 0));
            check("deq_pc", deq_pc_D, (exp_q.size() > 0) ? exp_q[0] : 64'h0);
            check("deq_instr", 64'(deq_instr_D), (exp_q.size() > 0) ? 64'(exp_instr_q[0]) : 64'h0);
            case ((exp_q.size() == 0) ? EMPTY : (exp_q.size() == DEPTH) ? FULL : PARTIAL)
                EMPTY:   saw_empty = 1'b1;
                FULL:    saw_full = 1'b1;
                default: saw_partial = 1'b1;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [N-1:0] pc, input logic [31:0] ins,
                         input logic dr, input logic fl);
        enq_valid_F = ev;
        enq_pc_F    = pc;
        enq_instr_F = ins;
        deq_ready_D = dr;
        flush_F     = fl;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        check("rst_count", 64'(count_F), 0);
        check("rst_enq_ready", 64'(enq_ready_F), 1);
        check("rst_deq_valid", 64'(deq_valid_D), 0);
        check("rst_deq_pc", deq_pc_D, 0);
        check("rst_deq_instr", 64'(deq_instr_D), 0);

        // Fill to FULL with decode stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(4 * i), 32'h8B020020 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        check("fill_count", 64'(count_F), 4);
        check("fill_enq_ready", 64'(enq_ready_F), 0);
        drive(1'b1, 64'h10, 32'h8B020024, 1'b0, 1'b0);
        tick();
        check("fifth_ignored_count", 64'(count_F), 4);
        check("fifth_head_pc", deq_pc_D, 64'h0);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            check("drain_pc", deq_pc_D, 64'(4 * i));
            check("drain_instr", 64'(deq_instr_D), 64'(32'h8B020020 + 32'(i)));
            tick();
        end
        check("drain_empty", 64'(deq_valid_D), 0);

        // Sustained streaming at count 1, wrapping the pointers.
        drive(1'b1, 64'h200, 32'hA0000000, 1'b0, 1'b0);
        tick();
        check("stream_start_count", 64'(count_F), 1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 64'h204 + 64'(4 * i), 32'hA0000001 + 32'(i), 1'b1, 1'b0);
            check("stream_head_pc", deq_pc_D, 64'h200 + 64'(4 * i));
            tick();
            check("stream_count", 64'(count_F), 1);
        end
        check("stream_end_pc", deq_pc_D, 64'h228);

        // Full with simultaneous enqueue and dequeue: only dequeue fires.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h300 + 64'(4 * i), 32'hB0000000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        check("full2_count", 64'(count_F), 4);
        drive(1'b1, 64'h30C, 32'hB0000003, 1'b1, 1'b0);
        tick();
        check("full_deq_count", 64'(count_F), 3);
        check("full_recover_ready", 64'(enq_ready_F), 1);
        check("full_deq_head", deq_pc_D, 64'h300);

        // Flush at count 3 with a concurrent enqueue of 0x40.
        drive(1'b1, 64'h40, 32'hC0000040, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        check("flush_count", 64'(count_F), 0);
        check("flush_deq_valid", 64'(deq_valid_D), 0);
        tick();
        tick();

        // Empty-to-valid latency, then reset with count 2.
        drive(1'b1, 64'h100, 32'h12345678, 1'b0, 1'b0);
        check("lat_before", 64'(deq_valid_D), 0);
        tick();
        check("lat_valid", 64'(deq_valid_D), 1);
        check("lat_pc", deq_pc_D, 64'h100);
        check("lat_instr", 64'(deq_instr_D), 64'h12345678);
        drive(1'b1, 64'h104, 32'h12345679, 1'b0, 1'b0);
        tick();
        check("pre_rst_count", 64'(count_F), 2);
        reset = 1'b1;
        drive(1'b1, 64'h108, 32'h1234567A, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        check("mid_rst_count", 64'(count_F), 0);
        check("mid_rst_valid", 64'(deq_valid_D), 0);
        check("mid_rst_pc", deq_pc_D, 0);
        tick();
        tick();

        check("no_0x40_dequeued", 64'(seen_40), 0);
        check("cov_empty", 64'(saw_empty), 1);
        check("cov_partial", 64'(saw_partial), 1);
        check("cov_full", 64'(saw_full), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
